mcu_param: RTL and testbench

MCU_PARAM -- requirements
Module: mcu_param

---
 rtl/mcu_param.sv | 225 ++++++++++++++++++++++
 tb/tb_mcu_param.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_param.sv
// Window-sequencing controller: walks a frame of pixel windows through read, grayscale,
// optional gradient and write phases, with one-cycle registered command strobes and handshake timeouts.
module mcu_param #(
  parameter int unsigned WIN_PIX = 9,
  parameter int unsigned OUT_PIX = 1,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_mode,
  input  logic [CNT_W-1:0] i_num_windows,
  input  logic             i_raddr_ready,
  input  logic             i_read_complete,
  input  logic             i_grayscale_data_ready,
  input  logic             i_gradient_data_ready,
  input  logic             i_waddr_ready,
  input  logic             i_write_complete,
  output logic             o_inc_raddr,
  output logic             o_re,
  output logic             o_grayscale_start,
  output logic             o_b1_save,
  output logic             o_b1_clear,
  output logic             o_gradient_start,
  output logic             o_b2_save,
  output logic             o_inc_waddr,
  output logic             o_we,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [CNT_W-1:0] o_win_count
);

  typedef enum logic [4:0] {
    S_IDLE, S_RADDR, S_RADDR_WAIT, S_READ, S_READ_WAIT, S_GRAY, S_GRAY_WAIT,
    S_B1_SAVE, S_EDGE, S_EDGE_WAIT, S_B2_SAVE, S_WADDR, S_WADDR_WAIT,
    S_WRITE, S_WRITE_WAIT, S_NEXT_WIN, S_DONE, S_ERROR
  } state_e;

  typedef struct packed {
    logic inc_raddr;
    logic re;
    logic gray_start;
    logic b1_save;
    logic b1_clear;
    logic grad_start;
    logic b2_save;
    logic inc_waddr;
    logic we;
  } strobe_t;

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [7:0]  WIN_PIX_C = 8'(WIN_PIX);
  localparam logic [7:0]  OUT_PIX_C = 8'(OUT_PIX);

  state_e           state_q,   state_d;
  strobe_t          strb_q,    strb_d;
  logic [7:0]       rd_cnt_q,  rd_cnt_d;
  logic [7:0]       wr_cnt_q,  wr_cnt_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] num_win_q, num_win_d;
  logic             mode_q,    mode_d;
  logic [15:0]      timer_q,   timer_d;

  logic             in_wait;
  logic             timed_out;
  logic [7:0]       out_pix_eff;
  logic [7:0]       rd_inc;
  logic [7:0]       wr_inc;
  logic [CNT_W-1:0] win_inc;

  // Grayscale-only mode produces a single output pixel per window.
  assign out_pix_eff = mode_q ? 8'd1 : OUT_PIX_C;
  assign rd_inc      = rd_cnt_q + 8'd1;
  assign wr_inc      = wr_cnt_q + 8'd1;
  assign win_inc     = win_cnt_q + CNT_W'(1);
  assign in_wait     = state_q inside {S_RADDR_WAIT, S_READ_WAIT, S_GRAY_WAIT,
                                       S_EDGE_WAIT, S_WADDR_WAIT, S_WRITE_WAIT};
  assign timed_out   = (timer_q == TMO_LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    win_cnt_d = win_cnt_q;
    num_win_d = num_win_q;
    mode_d    = mode_q;
    timer_d   = in_wait ? timer_q + 16'd1 : 16'd0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          mode_d    = i_mode;
          num_win_d = i_num_windows;
          rd_cnt_d  = '0;
          wr_cnt_d  = '0;
          win_cnt_d = '0;
          state_d   = (i_num_windows == '0) ? S_DONE : S_RADDR;
        end
      end
      S_RADDR: state_d = S_RADDR_WAIT;
      S_RADDR_WAIT: begin
        if (i_raddr_ready)  state_d = S_READ;
        else if (timed_out) state_d = S_ERROR;
      end
      S_READ: state_d = S_READ_WAIT;
      S_READ_WAIT: begin
        if (i_read_complete) state_d = S_GRAY;
        else if (timed_out)  state_d = S_ERROR;
      end
      S_GRAY: state_d = S_GRAY_WAIT;
      S_GRAY_WAIT: begin
        if (i_grayscale_data_ready) state_d = S_B1_SAVE;
        else if (timed_out)         state_d = S_ERROR;
      end
      S_B1_SAVE: begin
        if (mode_q) begin
          state_d = S_B2_SAVE;
        end else if (rd_inc < WIN_PIX_C) begin
          rd_cnt_d = rd_inc;
          state_d  = S_RADDR;
        end else begin
          rd_cnt_d = '0;
          state_d  = S_EDGE;
        end
      end
      S_EDGE: state_d = S_EDGE_WAIT;
      S_EDGE_WAIT: begin
        if (i_gradient_data_ready) state_d = S_B2_SAVE;
        else if (timed_out)        state_d = S_ERROR;
      end
      S_B2_SAVE: state_d = S_WADDR;
      S_WADDR:   state_d = S_WADDR_WAIT;
      S_WADDR_WAIT: begin
        if (i_waddr_ready)  state_d = S_WRITE;
        else if (timed_out) state_d = S_ERROR;
      end
      S_WRITE: state_d = S_WRITE_WAIT;
      S_WRITE_WAIT: begin
        if (i_write_complete) begin
          if (wr_inc < out_pix_eff) begin
            wr_cnt_d = wr_inc;
            state_d  = S_B2_SAVE;
          end else begin
            wr_cnt_d = '0;
            state_d  = S_NEXT_WIN;
          end
        end else if (timed_out) begin
          state_d = S_ERROR;
        end
      end
      S_NEXT_WIN: begin
        win_cnt_d = win_inc;
        state_d   = (win_inc == num_win_q) ? S_DONE : S_RADDR;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a simultaneous start.
    if (i_stop) begin
      state_d   = S_IDLE;
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
      win_cnt_d = '0;
      timer_d   = '0;
      mode_d    = mode_q;
      num_win_d = num_win_q;
    end
  end

  always_comb begin
    strb_d            = '0;
    strb_d.inc_raddr  = (state_q == S_RADDR);
    strb_d.re         = (state_q == S_READ);
    strb_d.gray_start = (state_q == S_GRAY);
    strb_d.b1_save    = (state_q == S_B1_SAVE);
    strb_d.b1_clear   = (state_q == S_B2_SAVE) && (wr_cnt_q == '0);
    strb_d.grad_start = (state_q == S_EDGE);
    strb_d.b2_save    = (state_q == S_B2_SAVE);
    strb_d.inc_waddr  = (state_q == S_WADDR);
    strb_d.we         = (state_q == S_WRITE);
    if (i_stop) strb_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      strb_q    <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      win_cnt_q <= '0;
      num_win_q <= '0;
      mode_q    <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      strb_q    <= strb_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      win_cnt_q <= win_cnt_d;
      num_win_q <= num_win_d;
      mode_q    <= mode_d;
      timer_q   <= timer_d;
    end
  end

  assign o_inc_raddr       = strb_q.inc_raddr;
  assign o_re              = strb_q.re;
  assign o_grayscale_start = strb_q.gray_start;
  assign o_b1_save         = strb_q.b1_save;
  assign o_b1_clear        = strb_q.b1_clear;
  assign o_gradient_start  = strb_q.grad_start;
  assign o_b2_save         = strb_q.b2_save;
  assign o_inc_waddr       = strb_q.inc_waddr;
  assign o_we              = strb_q.we;
  assign o_busy            = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign o_done            = (state_q == S_DONE);
  assign o_error           = (state_q == S_ERROR);
  assign o_win_count       = win_cnt_q;

endmodule

// File: tb/tb_mcu_param.sv
// Bench for mcu_param: strobe totals and busy-cycle counts per frame are predicted
// from the window/pixel arithmetic and compared with what the controller emits.
module tb_mcu_param;

  localparam int WIN_PIX = 9;
  localparam int OUT_PIX = 1;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             i_start = 1'b0;
  logic             i_stop = 1'b0;
  logic             i_mode = 1'b0;
  logic [CNT_W-1:0] i_num_windows = '0;
  logic [5:0]       rdy = '0;  // raddr, read, gray, grad, waddr, write

  logic o_inc_raddr, o_re, o_grayscale_start, o_b1_save, o_b1_clear;
  logic o_gradient_start, o_b2_save, o_inc_waddr, o_we;
  logic o_busy, o_done, o_error;
  logic [CNT_W-1:0] o_win_count;
  logic [8:0] strb_all;

  assign strb_all = {o_inc_raddr, o_re, o_grayscale_start, o_b1_save, o_b1_clear,
                     o_gradient_start, o_b2_save, o_inc_waddr, o_we};

  mcu_param #(.WIN_PIX(WIN_PIX), .OUT_PIX(OUT_PIX), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
    .i_num_windows(i_num_windows),
    .i_raddr_ready(rdy[0]), .i_read_complete(rdy[1]), .i_grayscale_data_ready(rdy[2]),
    .i_gradient_data_ready(rdy[3]), .i_waddr_ready(rdy[4]), .i_write_complete(rdy[5]),
    .o_inc_raddr(o_inc_raddr), .o_re(o_re), .o_grayscale_start(o_grayscale_start),
    .o_b1_save(o_b1_save), .o_b1_clear(o_b1_clear), .o_gradient_start(o_gradient_start),
    .o_b2_save(o_b2_save), .o_inc_waddr(o_inc_waddr), .o_we(o_we),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_win_count(o_win_count)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  int    cnt   [0:9];
  int    exp_c [0:9];
  int    streak[0:5];
  string nm    [0:9] = '{"inc_raddr", "re", "gray_start", "b1_save", "b1_clear",
                         "grad_start", "b2_save", "inc_waddr", "we", "busy_cycles"};

  // Reference: totals per frame follow directly from windows x pixels.
  function automatic void model(input bit mode, input int n);
    int pix, outs;
    pix  = mode ? 1 : WIN_PIX;
    outs = mode ? 1 : OUT_PIX;
    exp_c[0] = n * pix;
    exp_c[1] = n * pix;
    exp_c[2] = n * pix;
    exp_c[3] = n * pix;
    exp_c[4] = n;
    exp_c[5] = mode ? 0 : n;
    exp_c[6] = n * outs;
    exp_c[7] = n * outs;
    exp_c[8] = n * outs;
    // With readies tied high every state lasts exactly one cycle.
    exp_c[9] = n * (7 * pix + (mode ? 0 : 2) + 5 * outs + 1);
  endfunction

  task automatic drive_ready(input bit rnd);
    for (int i = 0; i < 6; i++) begin
      if (!rnd || streak[i] >= 3 || $urandom_range(0, 1) == 1) begin
        rdy[i]    = 1'b1;
        streak[i] = 0;
      end else begin
        rdy[i]    = 1'b0;
        streak[i] = streak[i] + 1;
      end
    end
  endtask

  // Starts a frame from a negedge and samples each cycle until done/error.
  task automatic run_frame(input bit mode, input int n, input bit rnd, output bit finished);
    for (int i = 0; i < 10; i++) cnt[i] = 0;
    for (int i = 0; i < 6; i++) streak[i] = 0;
    i_mode        = mode;
    i_num_windows = CNT_W'(n);
    drive_ready(rnd);
    i_start  = 1'b1;
    finished = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      cnt[0] += int'(o_inc_raddr);
      cnt[1] += int'(o_re);
      cnt[2] += int'(o_grayscale_start);
      cnt[3] += int'(o_b1_save);
      cnt[4] += int'(o_b1_clear);
      cnt[5] += int'(o_gradient_start);
      cnt[6] += int'(o_b2_save);
      cnt[7] += int'(o_inc_waddr);
      cnt[8] += int'(o_we);
      cnt[9] += int'(o_busy);
      if (o_done || o_error) begin
        finished = 1'b1;
        break;
      end
      drive_ready(rnd);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (strb_all !== 9'h0) begin
      n_errors++; $display("FAIL reset_strobes got %h expected 000", strb_all);
    end
    n_checks++;
    if ({o_busy, o_done, o_error} !== 3'b000) begin
      n_errors++; $display("FAIL reset_flags got %b expected 000", {o_busy, o_done, o_error});
    end
    n_checks++;
    if (o_win_count !== '0) begin
      n_errors++; $display("FAIL reset_win_count got %0d expected 0", o_win_count);
    end
  endtask

  task automatic test_first_start();
    rdy           = '1;
    i_mode        = 1'b0;
    i_num_windows = CNT_W'(1);
    n_rst         = 1'b1;
    i_start       = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_errors++; $display("FAIL first_start_busy got %b expected 1", o_busy);
    end
    @(negedge clk);
    n_checks++;
    if (o_inc_raddr !== 1'b1) begin
      n_errors++; $display("FAIL first_start_inc_raddr got %b expected 1", o_inc_raddr);
    end
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    n_checks++;
    if ({o_busy, o_done, o_error} !== 3'b000) begin
      n_errors++; $display("FAIL first_start_stop got %b expected 000", {o_busy, o_done, o_error});
    end
  endtask

  task automatic test_frame_tied(input bit mode, input int n, input string tag);
    bit fin;
    run_frame(mode, n, 1'b0, fin);
    model(mode, n);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (cnt[i] !== exp_c[i]) begin
        n_errors++; $display("FAIL %s_%s got %0d expected %0d", tag, nm[i], cnt[i], exp_c[i]);
      end
    end
    n_checks++;
    if (!fin || o_done !== 1'b1 || o_error !== 1'b0) begin
      n_errors++; $display("FAIL %s_done got done=%b error=%b fin=%b expected done=1", tag, o_done, o_error, fin);
    end
    n_checks++;
    if (o_win_count !== CNT_W'(n)) begin
      n_errors++; $display("FAIL %s_win_count got %0d expected %0d", tag, o_win_count, n);
    end
  endtask

  task automatic test_zero_windows();
    i_mode        = 1'b0;
    i_num_windows = '0;
    i_start       = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n_checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      n_errors++; $display("FAIL zero_win_done got done=%b busy=%b expected done=1 busy=0", o_done, o_busy);
    end
    n_checks++;
    if (strb_all !== 9'h0) begin
      n_errors++; $display("FAIL zero_win_strobes got %h expected 000", strb_all);
    end
    @(negedge clk);
    n_checks++;
    if (strb_all !== 9'h0 || o_done !== 1'b1) begin
      n_errors++; $display("FAIL zero_win_hold got strobes=%h done=%b expected 000/1", strb_all, o_done);
    end
  endtask

  task automatic test_timeout();
    int k;
    bit seen, fin;
    rdy           = 6'b110111;
    i_mode        = 1'b0;
    i_num_windows = CNT_W'(1);
    i_start       = 1'b1;
    seen          = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_gradient_start) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_errors++; $display("FAIL timeout_reach_edge got none expected gradient_start");
    end
    k = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      k = cyc;
      if (o_error) break;
    end
    n_checks++;
    if (k !== TIMEOUT || o_error !== 1'b1) begin
      n_errors++; $display("FAIL timeout_cycles got %0d (error=%b) expected %0d", k, o_error, TIMEOUT);
    end
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_errors++; $display("FAIL timeout_busy got %b expected 0", o_busy);
    end
    // Restart directly out of ERROR.
    run_frame(1'b1, 1, 1'b0, fin);
    n_checks++;
    if (!fin || o_done !== 1'b1 || o_error !== 1'b0 || cnt[8] !== 1) begin
      n_errors++; $display("FAIL error_restart got done=%b error=%b we=%0d expected 1/0/1", o_done, o_error, cnt[8]);
    end
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    n_checks++;
    if ({o_busy, o_done, o_error} !== 3'b000) begin
      n_errors++; $display("FAIL done_stop got %b expected 000", {o_busy, o_done, o_error});
    end
  endtask

  task automatic test_ready_last_cycle();
    bit seen, fin;
    rdy           = 6'b110111;
    i_mode        = 1'b0;
    i_num_windows = CNT_W'(1);
    i_start       = 1'b1;
    seen          = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_gradient_start) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (TIMEOUT - 1) @(negedge clk);
    n_checks++;
    if (!seen || o_error !== 1'b0 || o_busy !== 1'b1) begin
      n_errors++; $display("FAIL last_cycle_wait got error=%b busy=%b expected 0/1", o_error, o_busy);
    end
    rdy[3] = 1'b1;
    fin    = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (o_done || o_error) begin
        fin = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!fin || o_done !== 1'b1 || o_error !== 1'b0) begin
      n_errors++; $display("FAIL last_cycle_ready got done=%b error=%b expected 1/0", o_done, o_error);
    end
  endtask

  task automatic test_stop_mid();
    int  res;
    bit  fin;
    rdy           = '1;
    i_mode        = 1'b0;
    i_num_windows = CNT_W'(2);
    i_start       = 1'b1;
    res           = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      res += int'(o_re);
      if (res == 5) break;
    end
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    n_checks++;
    if (res !== 5 || {o_busy, o_done, o_error} !== 3'b000 || o_win_count !== '0 || strb_all !== 9'h0) begin
      n_errors++; $display("FAIL stop_mid got re=%0d flags=%b win=%0d strobes=%h expected 5/000/0/000",
                           res, {o_busy, o_done, o_error}, o_win_count, strb_all);
    end
    run_frame(1'b0, 1, 1'b0, fin);
    model(1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (cnt[i] !== exp_c[i]) begin
        n_errors++; $display("FAIL stop_restart_%s got %0d expected %0d", nm[i], cnt[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int wes;
    rdy           = '1;
    i_mode        = 1'b0;
    i_num_windows = CNT_W'(2);
    i_start       = 1'b1;
    wes           = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      wes += int'(o_we);
      if (wes == 2) break;
    end
    n_checks++;
    if (wes !== 2 || o_we !== 1'b1 || o_win_count !== CNT_W'(1)) begin
      n_errors++; $display("FAIL reset_mid_setup got we=%0d win=%0d expected 2/1", wes, o_win_count);
    end
    n_rst = 1'b0;
    #1;
    n_checks++;
    if (strb_all !== 9'h0 || {o_busy, o_done, o_error} !== 3'b000 || o_win_count !== '0) begin
      n_errors++; $display("FAIL reset_mid_async got strobes=%h flags=%b win=%0d expected 000/000/0",
                           strb_all, {o_busy, o_done, o_error}, o_win_count);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_busy, o_done, o_error} !== 3'b000 || strb_all !== 9'h0) begin
      n_errors++; $display("FAIL reset_mid_idle got flags=%b strobes=%h expected 000/000", {o_busy, o_done, o_error}, strb_all);
    end
  endtask

  task automatic test_random();
    bit mode, fin;
    int n;
    for (int f = 0; f < 8; f++) begin
      mode = 1'($urandom_range(0, 1));
      n    = int'($urandom_range(1, 4));
      run_frame(mode, n, 1'b1, fin);
      model(mode, n);
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (cnt[i] !== exp_c[i]) begin
          n_errors++; $display("FAIL rand%0d_%s got %0d expected %0d (mode=%0d n=%0d)", f, nm[i], cnt[i], exp_c[i], mode, n);
        end
      end
      n_checks++;
      if (!fin || o_done !== 1'b1 || o_win_count !== CNT_W'(n)) begin
        n_errors++; $display("FAIL rand%0d_end got done=%b win=%0d expected 1/%0d", f, o_done, o_win_count, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_start();
    test_frame_tied(1'b0, 2, "edge2");
    test_frame_tied(1'b1, 3, "gray3");
    test_zero_windows();
    test_timeout();
    test_ready_last_cycle();
    test_stop_mid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
